// File: rtl/sw_run_sequencer.sv
// rtl/sw_run_sequencer.sv - stand-alone set-target + N_RUNS scoring sequencer around FPGAWrapper; SW_RUN_CYCLES_EN adds cycle counts
module sw_run_sequencer #(
    parameter int N_RUNS    = 2,
    parameter int RESULT_W  = 16,
    parameter int GUARD     = 2,
    parameter int TIMEOUT_W = 26
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_go,
    input  logic                i_param_we,
    input  logic [3:0]          i_param_addr,
    input  logic [15:0]         i_param_data,
    output logic                o_set_t,
    output logic                o_start_cal,
    output logic [15:0]         o_param,
    input  logic                i_busy,
    input  logic                i_valid,
    input  logic [RESULT_W-1:0] i_result,
    input  logic [3:0]          i_rd_addr,
    output logic [RESULT_W-1:0] o_rd_data,
    output logic [RESULT_W-1:0] o_best,
    output logic [3:0]          o_best_idx,
    output logic                o_running,
    output logic                o_done,
`ifdef SW_RUN_CYCLES_EN
    output logic [31:0]         o_cycles,
    output logic [31:0]         o_rd_cycles,
`endif
    output logic                o_error
);
    localparam int GCW = $clog2(GUARD + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETP, S_SETW, S_LOAD, S_PRE, S_START, S_VALW, S_IDLW, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            run_q, run_d;
    logic [15:0]           param_q, param_d;
    logic [RESULT_W-1:0]   best_q, best_d;
    logic [3:0]            best_idx_q, best_idx_d;
    logic                  error_q, error_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic [GCW-1:0]        guard_q, guard_d;
    logic                  set_t_q, set_t_d;
    logic                  start_cal_q, start_cal_d;
    logic                  running_q, running_d;
    logic                  done_q, done_d;
    logic [RESULT_W-1:0]   rd_data_q, rd_data_d;
    logic [15:0]           pbank_q [16];
    logic [RESULT_W-1:0]   res_q [16];
    logic                  res_we;
    logic                  wait_st;
    logic                  guard_done;

    assign wait_st    = (state_q == S_SETW) || (state_q == S_VALW) || (state_q == S_IDLW);
    assign guard_done = (guard_q >= GCW'(GUARD));

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        param_d    = param_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        error_d    = error_q;
        res_we     = 1'b0;
        wd_d       = wait_st ? wd_q + TIMEOUT_W'(1) : '0;
        guard_d    = guard_done ? guard_q : guard_q + GCW'(1);
        case (state_q)
            S_IDLE: if (i_go) begin
                error_d    = 1'b0;
                best_d     = '0;
                best_idx_d = '0;
                run_d      = '0;
                state_d    = S_SETP;
            end
            S_SETP:  state_d = S_SETW;
            S_SETW:  if (guard_done && !i_busy) state_d = S_LOAD;
            S_LOAD: begin
                param_d = pbank_q[run_q];
                state_d = S_PRE;
            end
            S_PRE:   state_d = S_START;
            S_START: state_d = S_VALW;
            S_VALW: if (i_valid) begin
                res_we = 1'b1;
                if (i_result > best_q) begin
                    best_d     = i_result;
                    best_idx_d = run_q;
                end
                state_d = S_IDLW;
            end
            S_IDLW: if (!i_busy) begin
                if (run_q == 4'(N_RUNS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    run_d   = run_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Watchdog only fires when the wait state would otherwise persist.
        if (wait_st && (state_d == state_q) && (wd_d == '1)) begin
            error_d = 1'b1;
            state_d = S_DONE;
        end
        if (state_d != state_q) begin
            wd_d    = '0;
            guard_d = '0;
        end
        set_t_d     = (state_d == S_SETP);
        start_cal_d = (state_d == S_START);
        done_d      = (state_d == S_DONE);
        running_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        rd_data_d   = (int'(i_rd_addr) < N_RUNS) ? res_q[i_rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            run_q       <= '0;
            param_q     <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            error_q     <= 1'b0;
            wd_q        <= '0;
            guard_q     <= '0;
            set_t_q     <= 1'b0;
            start_cal_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                pbank_q[i] <= '0;
                res_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            param_q     <= param_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            error_q     <= error_d;
            wd_q        <= wd_d;
            guard_q     <= guard_d;
            set_t_q     <= set_t_d;
            start_cal_q <= start_cal_d;
            running_q   <= running_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            if (i_param_we && (int'(i_param_addr) < N_RUNS))
                pbank_q[i_param_addr] <= i_param_data;
            if (res_we)
                res_q[run_q] <= i_result;
        end
    end

`ifdef SW_RUN_CYCLES_EN
    logic [31:0] cyc_run_q, cyc_run_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] rd_cycles_q, rd_cycles_d;
    logic [31:0] cbank_q [16];
    logic        go_acc;

    assign go_acc = (state_q == S_IDLE) && i_go;

    always_comb begin
        cyc_run_d   = (state_q == S_START) ? 32'd1 :
                      (state_q == S_VALW)  ? cyc_run_q + 32'd1 : cyc_run_q;
        cycles_d    = go_acc ? 32'd0 : (res_we ? cyc_run_q + 32'd1 : cycles_q);
        rd_cycles_d = (int'(i_rd_addr) < N_RUNS) ? cbank_q[i_rd_addr] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_run_q   <= '0;
            cycles_q    <= '0;
            rd_cycles_q <= '0;
            for (int i = 0; i < 16; i++) cbank_q[i] <= '0;
        end else begin
            cyc_run_q   <= cyc_run_d;
            cycles_q    <= cycles_d;
            rd_cycles_q <= rd_cycles_d;
            if (go_acc)
                for (int i = 0; i < 16; i++) cbank_q[i] <= '0;
            else if (res_we)
                cbank_q[run_q] <= cyc_run_q + 32'd1;
        end
    end

    assign o_cycles    = cycles_q;
    assign o_rd_cycles = rd_cycles_q;
`endif

    assign o_set_t     = set_t_q;
    assign o_start_cal = start_cal_q;
    assign o_param     = param_q;
    assign o_rd_data   = rd_data_q;
    assign o_best      = best_q;
    assign o_best_idx  = best_idx_q;
    assign o_running   = running_q;
    assign o_done      = done_q;
    assign o_error     = error_q;
endmodule

// File: tb/tb_sw_run_sequencer.sv
// tb/tb_sw_run_sequencer.sv - bench for sw_run_sequencer with a behavioural FPGAWrapper model
module tb_sw_run_sequencer;
    localparam int NR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_go = 1'b0;
    logic        i_param_we = 1'b0;
    logic [3:0]  i_param_addr = '0;
    logic [15:0] i_param_data = '0;
    logic        o_set_t, o_start_cal;
    logic [15:0] o_param;
    logic        i_busy = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_result = '0;
    logic [3:0]  i_rd_addr = '0;
    logic [15:0] o_rd_data, o_best;
    logic [3:0]  o_best_idx;
    logic        o_running, o_done, o_error;

    sw_run_sequencer #(.N_RUNS(NR), .RESULT_W(16), .GUARD(2), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go),
        .i_param_we(i_param_we), .i_param_addr(i_param_addr), .i_param_data(i_param_data),
        .o_set_t(o_set_t), .o_start_cal(o_start_cal), .o_param(o_param),
        .i_busy(i_busy), .i_valid(i_valid), .i_result(i_result),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_best(o_best), .o_best_idx(o_best_idx),
        .o_running(o_running), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wrapper model: busy from 3 to 8 cycles after each pulse, result at 6 (optional echo 99 at 7).
    int          t = 100;
    int          ncnt = 0;
    bit          is_start = 0;
    int          cur = 0;
    int          set_cnt = 0, start_cnt = 0, done_cnt = 0;
    int          last_start_n = 0, done_n = 0;
    logic [15:0] prev_param = '0;
    logic [15:0] cap_param [16];
    logic [15:0] cap_prev [16];
    int          seq_base = 0;
    logic [15:0] res_tab [16];
    bit          val_en [16];
    bit          dbl_en [16];

    always @(negedge clk) begin
        ncnt++;
        if (!rst_n) begin
            t = 100; is_start = 0; i_busy = 0; i_valid = 0;
        end else begin
            i_valid = 0;
            if (o_set_t) begin
                set_cnt++; t = 0; is_start = 0;
            end else if (o_start_cal) begin
                cur = (start_cnt - seq_base) & 15;
                cap_param[cur] = o_param;
                cap_prev[cur]  = prev_param;
                start_cnt++; last_start_n = ncnt; t = 0; is_start = 1;
            end else if (t < 100) begin
                t++;
            end
            i_busy = (t >= 3 && t <= 8);
            if (is_start && t == 6 && val_en[cur]) begin i_valid = 1; i_result = res_tab[cur]; end
            if (is_start && t == 7 && dbl_en[cur]) begin i_valid = 1; i_result = 16'd99; end
            if (o_done) begin done_cnt++; done_n = ncnt; end
            prev_param = o_param;
        end
    end

    typedef struct {
        logic [15:0] p0, p1, r0, r1;
        logic [15:0] exp_best;
        logic [3:0]  exp_idx;
    } vec_t;
    vec_t vecs [5];

    int b_set, b_start, b_done;

    task automatic wr(input int a, input logic [15:0] d);
        i_param_we = 1; i_param_addr = 4'(a); i_param_data = d;
        @(negedge clk);
        i_param_we = 0;
    endtask

    task automatic rd(input int a, input logic [15:0] e, input string nm);
        i_rd_addr = 4'(a);
        @(negedge clk);
        check(nm, 32'(o_rd_data), 32'(e));
    endtask

    task automatic pulse_go();
        i_go = 1;
        @(negedge clk);
        i_go = 0;
    endtask

    task automatic begin_seq();
        b_set = set_cnt; b_start = start_cnt; b_done = done_cnt; seq_base = start_cnt;
        pulse_go();
        check("running_after_go", 32'(o_running), 32'd1);
    endtask

    task automatic wait_start();
        int c = 0;
        while (start_cnt == b_start && c < 200) begin @(negedge clk); c++; end
        check("first_start_seen", 32'(start_cnt - b_start), 32'd1);
    endtask

    task automatic wait_done();
        int c = 0;
        while (done_cnt == b_done && c < 2000) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt - b_done), 32'd1);
    endtask

    task automatic seq_checks(input int starts, input logic [15:0] pa, input logic [15:0] pb);
        check("set_pulses", 32'(set_cnt - b_set), 32'd1);
        check("start_pulses", 32'(start_cnt - b_start), 32'(starts));
        check("running_off", 32'(o_running), 32'd0);
        for (int k = 0; k < starts; k++) begin
            check("param_at_start", 32'(cap_param[k]), 32'(k == 0 ? pa : pb));
            check("param_setup", 32'(cap_prev[k]), 32'(k == 0 ? pa : pb));
        end
    endtask

    task automatic run_vec(input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] r0, input logic [15:0] r1);
        wr(0, p0); wr(1, p1);
        res_tab[0] = r0; res_tab[1] = r1;
        begin_seq();
        wait_done();
        seq_checks(2, p0, p1);
        check("error_clear", 32'(o_error), 32'd0);
        rd(0, r0, "rd0");
        rd(1, r1, "rd1");
        rd(2, 16'd0, "rd_out_of_range");
    endtask

    // Reference: best is the maximum result; its index is the first run reaching it.
    function automatic void ref_best(output logic [15:0] b, output int idx);
        b = 0;
        for (int i = 0; i < NR; i++) if (res_tab[i] > b) b = res_tab[i];
        idx = 0;
        for (int i = NR - 1; i >= 0; i--) if (res_tab[i] == b) idx = i;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_set_t"}, 32'(o_set_t), 0);
        check({tag, "_start_cal"}, 32'(o_start_cal), 0);
        check({tag, "_param"}, 32'(o_param), 0);
        check({tag, "_rd_data"}, 32'(o_rd_data), 0);
        check({tag, "_best"}, 32'(o_best), 0);
        check({tag, "_best_idx"}, 32'(o_best_idx), 0);
        check({tag, "_running"}, 32'(o_running), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_error"}, 32'(o_error), 0);
    endtask

    initial begin
        logic [15:0] rb, r0, r1, last_r1;
        int          ri;
        vecs[0] = '{16'h2411, 16'h3522, 16'd37,   16'd52,  16'd52,   4'd1};
        vecs[1] = '{16'h1111, 16'h2222, 16'd40,   16'd40,  16'd40,   4'd0};
        vecs[2] = '{16'h0000, 16'hffff, 16'd0,    16'd0,   16'd0,    4'd0};
        vecs[3] = '{16'habcd, 16'h1234, 16'hffff, 16'd1,   16'hffff, 4'd0};
        vecs[4] = '{16'h5a5a, 16'ha5a5, 16'd100,  16'd101, 16'd101,  4'd1};
        for (int i = 0; i < 16; i++) begin res_tab[i] = '0; val_en[i] = 1; dbl_en[i] = 0; end

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1;
        @(negedge clk);
        check_zero("post_reset");

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v].p0, vecs[v].p1, vecs[v].r0, vecs[v].r1);
            check("vec_best", 32'(o_best), 32'(vecs[v].exp_best));
            check("vec_best_idx", 32'(o_best_idx), 32'(vecs[v].exp_idx));
        end

        for (int n = 0; n < 6; n++) begin
            r0 = 16'($urandom_range(0, 65535));
            r1 = ($urandom_range(0, 3) == 0) ? r0 : 16'($urandom_range(0, 65535));
            run_vec(16'($urandom), 16'($urandom), r0, r1);
            ref_best(rb, ri);
            check("rand_best", 32'(o_best), 32'(rb));
            check("rand_best_idx", 32'(o_best_idx), 32'(ri));
        end
        last_r1 = res_tab[1];

        // Watchdog: run 1 never produces a result.
        res_tab[0] = 16'd77; val_en[1] = 0;
        begin_seq();
        wait_done();
        check("wd_error", 32'(o_error), 32'd1);
        check("wd_start_pulses", 32'(start_cnt - b_start), 32'd2);
        check("wd_valw_cycles", 32'(done_n - last_start_n), 32'd256);
        check("wd_best", 32'(o_best), 32'd77);
        check("wd_best_idx", 32'(o_best_idx), 32'd0);
        check("wd_running", 32'(o_running), 32'd0);
        rd(1, last_r1, "wd_rd1_kept");
        rd(0, 16'd77, "wd_rd0");
        val_en[1] = 1; res_tab[1] = 16'd5;
        begin_seq();
        check("go_clears_error", 32'(o_error), 32'd0);
        wait_done();
        check("after_wd_error", 32'(o_error), 32'd0);
        rd(1, 16'd5, "after_wd_rd1");

        // Second go and a bank[0] write during run 0.
        wr(0, 16'h1357); wr(1, 16'h2468);
        res_tab[0] = 16'd11; res_tab[1] = 16'd22;
        begin_seq();
        wait_start();
        @(negedge clk);
        i_go = 1; i_param_we = 1; i_param_addr = 4'd0; i_param_data = 16'h9bdf;
        @(negedge clk);
        i_go = 0; i_param_we = 0;
        wait_done();
        seq_checks(2, 16'h1357, 16'h2468);
        begin_seq();
        wait_done();
        seq_checks(2, 16'h9bdf, 16'h2468);

        // Duplicate valid within one run.
        res_tab[0] = 16'd9; res_tab[1] = 16'd3; dbl_en[0] = 1;
        begin_seq();
        wait_done();
        rd(0, 16'd9, "dbl_first_only");
        check("dbl_best", 32'(o_best), 32'd9);
        check("dbl_best_idx", 32'(o_best_idx), 32'd0);
        dbl_en[0] = 0;

        // Asynchronous reset during VALW.
        i_rd_addr = 4'd0;
        begin_seq();
        wait_start();
        repeat (2) @(negedge clk);
        check("pre_reset_running", 32'(o_running), 32'd1);
        rst_n = 0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst_n = 1;
        rd(0, 16'd0, "bank_cleared");
        run_vec(16'h2411, 16'h3522, 16'd37, 16'd52);
        check("post_reset_best", 32'(o_best), 32'd52);
        check("post_reset_idx", 32'(o_best_idx), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
